// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response channel and the
// decoder-facing valid/ready output stream.
interface fetch_queue_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [31:0]     imem_rsp_data_i;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [XLEN-1:0] dec_pc_o;
  logic [31:0]     dec_data_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output dec_valid_o, dec_pc_o, dec_data_o,
    input  dec_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  dec_valid_o, dec_pc_o, dec_data_o,
    output dec_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: issues word fetches under a credit limit, pairs
// returned words with their PC and buffers them for the decoder; redirects flush it.
module fetch_queue #(
  parameter int              XLEN    = 64,
  parameter int              DEPTH   = 4,
  parameter logic [XLEN-1:0] BOOT_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_queue_if.master   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [XLEN-1:0] r_fetch_pc;
  cnt_t            r_inflight;
  cnt_t            r_drop;
  cnt_t            r_count;
  logic [XLEN-1:0] r_pq [DEPTH];
  ptr_t            r_pq_wr;
  ptr_t            r_pq_rd;
  logic [XLEN-1:0] r_fifo_pc   [DEPTH];
  logic [31:0]     r_fifo_data [DEPTH];
  ptr_t            r_f_wr;
  ptr_t            r_f_rd;

  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp;
  logic            w_dec_valid;
  logic            w_push;
  logic            w_pop;
  cnt_t            w_inflight_nxt;
  cnt_t            w_drop_nxt;
  logic [XLEN-1:0] w_redirect_pc;

  // Credit counts squashed in-flight fetches too, so the FIFO can never overflow.
  assign w_credit       = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW + 1)'(DEPTH);
  assign w_req_valid    = !rst_i && w_credit;
  assign w_req_fire     = w_req_valid && bus.imem_req_ready_i;
  assign w_rsp          = bus.imem_rsp_valid_i && (r_inflight != '0);
  assign w_dec_valid    = (r_count != '0);
  assign w_push         = w_rsp && (r_drop == '0) && !redirect_valid_i;
  assign w_pop          = w_dec_valid && bus.dec_ready_i && !redirect_valid_i;
  assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_rsp);
  assign w_redirect_pc  = redirect_pc_i & ~(XLEN'(2'b11));

  assign bus.imem_req_valid_o = w_req_valid;
  assign bus.imem_req_addr_o  = r_fetch_pc;
  assign bus.dec_valid_o      = w_dec_valid;
  assign bus.dec_pc_o         = r_fifo_pc[r_f_rd];
  assign bus.dec_data_o       = r_fifo_data[r_f_rd];

  // A redirect marks everything still outstanding (after this cycle's events) as stale.
  always_comb begin
    w_drop_nxt = r_drop;
    if (redirect_valid_i) begin
      w_drop_nxt = w_inflight_nxt;
    end else if (w_rsp && (r_drop != '0)) begin
      w_drop_nxt = r_drop - CW'(1);
    end else begin
      w_drop_nxt = r_drop;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc <= BOOT_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      if (redirect_valid_i) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // PC queue tracks every issued fetch, squashed or not, so responses stay paired.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pq    <= '{default: '0};
      r_pq_wr <= '0;
      r_pq_rd <= '0;
    end else begin
      if (w_req_fire) begin
        r_pq[r_pq_wr] <= r_fetch_pc;
        r_pq_wr       <= ptr_inc(r_pq_wr);
      end
      if (w_rsp) begin
        r_pq_rd <= ptr_inc(r_pq_rd);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fifo_pc   <= '{default: '0};
      r_fifo_data <= '{default: '0};
      r_f_wr      <= '0;
      r_f_rd      <= '0;
      r_count     <= '0;
    end else if (redirect_valid_i) begin
      r_f_wr  <= '0;
      r_f_rd  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_f_wr]   <= r_pq[r_pq_rd];
        r_fifo_data[r_f_wr] <= bus.imem_rsp_data_i;
        r_f_wr              <= ptr_inc(r_f_wr);
      end
      if (w_pop) begin
        r_f_rd <= ptr_inc(r_f_rd);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_rsp_valid_i |-> (r_inflight != '0));
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    r_count <= CW'(DEPTH));
  a_drop_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    r_drop <= r_inflight);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a one-cycle-latency memory model with optional hold,
// and logs of accepted requests and consumed decoder entries.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cycle_cnt = 0;
  bit mem_hold = 1'b0;
  bit mem_tag = 1'b0;

  logic [XLEN-1:0] mem_q[$];
  logic [XLEN-1:0] req_addr[$];
  int              req_cyc[$];
  logic [XLEN-1:0] got_pc[$];
  logic [31:0]     got_data[$];
  int              got_cyc[$];

  fetch_queue_if #(.XLEN(XLEN)) bus();

  fetch_queue #(.XLEN(XLEN), .DEPTH(4), .BOOT_PC(64'h8000_0000)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .bus              (bus.master)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle_cnt++;
  end

  // Log handshakes mid-cycle while all inputs are stable.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
        req_addr.push_back(bus.imem_req_addr_o);
        req_cyc.push_back(cycle_cnt);
      end
      if (bus.dec_valid_o && bus.dec_ready_i && !redirect_valid) begin
        got_pc.push_back(bus.dec_pc_o);
        got_data.push_back(bus.dec_data_o);
        got_cyc.push_back(cycle_cnt);
      end
    end
  end

  // Memory: answers accepted requests in order, one per cycle, earliest the next cycle.
  initial begin
    logic [XLEN-1:0] a;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) mem_q.delete();
      else if (bus.imem_req_valid_o && bus.imem_req_ready_i) mem_q.push_back(bus.imem_req_addr_o);
      @(posedge clk);
      #2;
      if (!rst && !mem_hold && mem_q.size() != 0) begin
        a = mem_q.pop_front();
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = mem_tag ? {a[31:2], 2'b11} : 32'h0000_0013;
      end else begin
        bus.imem_rsp_valid_i = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_logs();
    req_addr.delete(); req_cyc.delete();
    got_pc.delete(); got_data.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_req_ready_i = 1'b0;
    bus.dec_ready_i = 1'b0;
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    run(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_req_ready_i = 1'b0;
    bus.dec_ready_i = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b, expected 0", bus.imem_req_valid_o); end
    n_checks++; if (bus.imem_req_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL rst_req_addr: got %h, expected 80000000", bus.imem_req_addr_o); end
    n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid: got %b, expected 0", bus.dec_valid_o); end
    n_checks++; if (bus.dec_pc_o !== 64'h0) begin n_fail++; $display("FAIL rst_dec_pc: got %h, expected 0", bus.dec_pc_o); end
    n_checks++; if (bus.dec_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_dec_data: got %h, expected 0", bus.dec_data_o); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_valid: got %b, expected 1", bus.imem_req_valid_o); end
    cyc();
  endtask

  task automatic test_basic_stream();
    do_reset();
    mem_tag = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.dec_ready_i = 1'b1;
    run(10);
    n_checks++; if (got_pc[0] !== 64'h8000_0000) begin n_fail++; $display("FAIL basic_pc0: got %h, expected 80000000", got_pc[0]); end
    n_checks++; if (got_pc[1] !== 64'h8000_0004) begin n_fail++; $display("FAIL basic_pc1: got %h, expected 80000004", got_pc[1]); end
    n_checks++; if (got_pc[2] !== 64'h8000_0008) begin n_fail++; $display("FAIL basic_pc2: got %h, expected 80000008", got_pc[2]); end
    n_checks++; if (got_data[0] !== 32'h13) begin n_fail++; $display("FAIL basic_data0: got %h, expected 00000013", got_data[0]); end
    n_checks++; if (got_data[2] !== 32'h13) begin n_fail++; $display("FAIL basic_data2: got %h, expected 00000013", got_data[2]); end
    n_checks++; if (got_cyc[0] - req_cyc[0] !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 2", got_cyc[0] - req_cyc[0]); end
    n_checks++; if (got_cyc[2] - got_cyc[0] !== 2) begin n_fail++; $display("FAIL basic_rate: got %0d, expected 2", got_cyc[2] - got_cyc[0]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_tag = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    run(10);
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b, expected 0", bus.imem_req_valid_o); end
    n_checks++; if (req_addr.size() !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d, expected 4", req_addr.size()); end
    cyc();
    bus.dec_ready_i = 1'b1;
    run(10);
    n_checks++; if (got_pc[0] !== 64'h8000_0000) begin n_fail++; $display("FAIL bp_pc0: got %h, expected 80000000", got_pc[0]); end
    n_checks++; if (got_pc[3] !== 64'h8000_000C) begin n_fail++; $display("FAIL bp_pc3: got %h, expected 8000000c", got_pc[3]); end
    n_checks++; if (got_data[1] !== 32'h8000_0007) begin n_fail++; $display("FAIL bp_data1: got %h, expected 80000007", got_data[1]); end
    n_checks++; if (req_addr[4] !== 64'h8000_0010) begin n_fail++; $display("FAIL bp_resume_addr: got %h, expected 80000010", req_addr[4]); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    mem_tag = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    cyc();
    bus.imem_req_ready_i = 1'b0;
    cyc();
    mem_hold = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    run(2);
    bus.imem_req_ready_i = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1003;
    @(negedge clk);
    n_checks++; if (bus.dec_pc_o !== 64'h8000_0000 || bus.dec_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_head: got %h/%b, expected 80000000/1", bus.dec_pc_o, bus.dec_valid_o); end
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b, expected 0", bus.dec_valid_o); end
    cyc();
    mem_hold = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.dec_ready_i = 1'b1;
    clear_logs();
    run(12);
    n_checks++; if (req_addr[0] !== 64'h8000_1000) begin n_fail++; $display("FAIL flush_req_addr: got %h, expected 80001000", req_addr[0]); end
    n_checks++; if (got_pc[0] !== 64'h8000_1000) begin n_fail++; $display("FAIL flush_pc0: got %h, expected 80001000", got_pc[0]); end
    n_checks++; if (got_data[0] !== 32'h8000_1003) begin n_fail++; $display("FAIL flush_data0: got %h, expected 80001003", got_data[0]); end
    n_checks++; if (got_pc[1] !== 64'h8000_1004) begin n_fail++; $display("FAIL flush_pc1: got %h, expected 80001004", got_pc[1]); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    mem_tag = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    bus.dec_ready_i = 1'b1;
    run(6);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    clear_logs();
    cyc();
    redirect_valid = 1'b0;
    run(10);
    n_checks++; if (req_addr[0] !== 64'h8000_0018) begin n_fail++; $display("FAIL same_redirect_req: got %h, expected 80000018", req_addr[0]); end
    n_checks++; if (req_addr[1] !== 64'h8000_2000) begin n_fail++; $display("FAIL same_new_req: got %h, expected 80002000", req_addr[1]); end
    n_checks++; if (got_pc[0] !== 64'h8000_2000) begin n_fail++; $display("FAIL same_pc0: got %h, expected 80002000", got_pc[0]); end
    n_checks++; if (got_pc[1] !== 64'h8000_2004) begin n_fail++; $display("FAIL same_pc1: got %h, expected 80002004", got_pc[1]); end
    n_checks++; if (got_data[1] !== 32'h8000_2007) begin n_fail++; $display("FAIL same_data1: got %h, expected 80002007", got_data[1]); end
  endtask

  task automatic test_stall_wrap();
    do_reset();
    mem_tag = 1'b1;
    bus.dec_ready_i = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    run(2);
    bus.imem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.imem_req_addr_o !== 64'h8000_0008 || bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h/%b, expected 80000008/1", i, bus.imem_req_addr_o, bus.imem_req_valid_o); end
      cyc();
    end
    n_checks++; if (req_addr.size() !== 2) begin n_fail++; $display("FAIL stall_no_req: got %0d, expected 2", req_addr.size()); end
    bus.imem_req_ready_i = 1'b1;
    cyc();
    bus.imem_req_ready_i = 1'b0;
    run(3);
    n_checks++; if (req_addr.size() !== 3 || req_addr[2] !== 64'h8000_0008) begin n_fail++; $display("FAIL stall_accept: got %0d/%h, expected 3/80000008", req_addr.size(), req_addr[2]); end
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    clear_logs();
    run(6);
    n_checks++; if (req_addr[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %h, expected fffffffffffffffc", req_addr[0]); end
    n_checks++; if (req_addr[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_req1: got %h, expected 0", req_addr[1]); end
    n_checks++; if (got_data[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_data0: got %h, expected ffffffff", got_data[0]); end
    n_checks++; if (got_pc[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_pc1: got %h, expected 0", got_pc[1]); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mem_tag = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    cyc();
    bus.imem_req_ready_i = 1'b0;
    cyc();
    mem_hold = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    run(3);
    bus.imem_req_ready_i = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req_valid: got %b, expected 0", bus.imem_req_valid_o); end
    n_checks++; if (bus.imem_req_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL mid_rst_addr: got %h, expected 80000000", bus.imem_req_addr_o); end
    n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dec_valid: got %b, expected 0", bus.dec_valid_o); end
    n_checks++; if (bus.dec_pc_o !== 64'h0 || bus.dec_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_dec_bus: got %h/%h, expected 0/0", bus.dec_pc_o, bus.dec_data_o); end
    cyc();
    rst = 1'b0;
    mem_hold = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    clear_logs();
    run(8);
    n_checks++; if (req_addr.size() !== 4) begin n_fail++; $display("FAIL mid_credit: got %0d, expected 4", req_addr.size()); end
    n_checks++; if (req_addr[0] !== 64'h8000_0000) begin n_fail++; $display("FAIL mid_first_addr: got %h, expected 80000000", req_addr[0]); end
    @(negedge clk);
    n_checks++; if (bus.dec_data_o !== 32'h8000_0003) begin n_fail++; $display("FAIL mid_head_data: got %h, expected 80000003", bus.dec_data_o); end
    cyc();
    bus.dec_ready_i = 1'b1;
    run(8);
    n_checks++; if (got_pc[1] !== 64'h8000_0004) begin n_fail++; $display("FAIL mid_pc1: got %h, expected 80000004", got_pc[1]); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_stall_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
